// File: rtl/piso_octal_reader.sv
// Parallel-in serial-out reader with valid/ready serial handshake.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_octal_reader #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] par_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(FRAME_LEN + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t               state_q, state_d;
  logic [FRAME_LEN-1:0] sreg_q, sreg_d;
  logic [FRAME_LEN-1:0] frame_word;
  logic [CW-1:0]        cnt_q, cnt_d;

  // Parity sits on the side of the register that shifts out last.
  always_comb begin
`ifdef PISO_PARITY_EN
    if (MSB_FIRST)
      frame_word = {par_in, ^par_in};
    else
      frame_word = {^par_in, par_in};
`else
    frame_word = par_in;
`endif
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          sreg_d  = frame_word;
          cnt_d   = CW'(FRAME_LEN);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          sreg_d = MSB_FIRST ? (sreg_q << 1)
                             : (sreg_q >> 1);
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1))
            state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode flops only; no input reaches an output.
  assign ser_valid   = (state_q == SHIFT);
  assign busy        = (state_q == SHIFT);
  assign load_ready  = (state_q == IDLE);
  assign ser_out     = MSB_FIRST ? sreg_q[FRAME_LEN-1]
                                 : sreg_q[0];
  assign frame_start = ser_valid &&
                       (cnt_q == CW'(FRAME_LEN));
  assign frame_end   = ser_valid && (cnt_q == CW'(1));

endmodule

// File: tb/tb_piso_octal_reader.sv
// Directed bench for piso_octal_reader.
// Two instances: MSB-first and LSB-first.
module tb_piso_octal_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_valid = 1'b0;
  logic load_valid_l = 1'b0;
  logic ser_ready = 1'b1;
  logic [7:0] par_in = 8'h00;

  logic load_ready, ser_out, ser_valid;
  logic frame_start, frame_end, busy;
  logic load_ready_l, ser_out_l, ser_valid_l;
  logic frame_start_l, frame_end_l, busy_l;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  piso_octal_reader #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .par_in(par_in),
    .load_valid(load_valid), .load_ready(load_ready),
    .ser_out(ser_out), .ser_valid(ser_valid),
    .ser_ready(ser_ready), .frame_start(frame_start),
    .frame_end(frame_end), .busy(busy)
  );

  piso_octal_reader #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .par_in(par_in),
    .load_valid(load_valid_l), .load_ready(load_ready_l),
    .ser_out(ser_out_l), .ser_valid(ser_valid_l),
    .ser_ready(ser_ready), .frame_start(frame_start_l),
    .frame_end(frame_end_l), .busy(busy_l)
  );

  // Observed vector order: ser_valid busy load_ready ser_out frame_start frame_end
  logic [5:0] obs, obs_l, e;

  assign obs = {ser_valid, busy, load_ready,
                ser_out, frame_start, frame_end};
  assign obs_l = {ser_valid_l, busy_l, load_ready_l,
                  ser_out_l, frame_start_l, frame_end_l};

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (obs !== 6'b001000) begin
      bad++;
      $display("FAIL reset_msb got=%b exp=001000", obs);
    end
    total++;
    if (obs_l !== 6'b001000) begin
      bad++;
      $display("FAIL reset_lsb got=%b exp=001000", obs_l);
    end
    rst = 1'b0;
  endtask

  task automatic test_msb_a5();
    logic [0:7] seq;
    seq = 8'b10100101;
    @(negedge clk);
    par_in = 8'hA5;
    load_valid = 1'b1;
    ser_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      e = {3'b110, seq[i], i == 0, i == 7};
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL a5_bit%0d got=%b exp=%b", i, obs, e);
      end
    end
    @(negedge clk);
    total++;
    if (obs !== 6'b001000) begin
      bad++;
      $display("FAIL a5_ready got=%b exp=001000", obs);
    end
  endtask

  task automatic test_lsb_01();
    logic [0:7] seq;
    seq = 8'b10000000;
    @(negedge clk);
    par_in = 8'h01;
    load_valid_l = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load_valid_l = 1'b0;
      e = {3'b110, seq[i], i == 0, i == 7};
      total++;
      if (obs_l !== e) begin
        bad++;
        $display("FAIL lsb01_bit%0d got=%b exp=%b", i, obs_l, e);
      end
    end
    @(negedge clk);
    total++;
    if (obs_l !== 6'b001000) begin
      bad++;
      $display("FAIL lsb01_ready got=%b exp=001000", obs_l);
    end
  endtask

  task automatic test_stall_c3();
    logic [0:7] seq;
    int k;
    int stall;
    seq = 8'b11000011;
    k = 0;
    stall = 0;
    @(negedge clk);
    par_in = 8'hC3;
    load_valid = 1'b1;
    for (int c = 0; c < 40 && k < 8; c++) begin
      @(negedge clk);
      load_valid = 1'b0;
      ser_ready = !(k == 1 && stall < 3);
      if (!ser_ready) stall++;
      e = {3'b110, seq[k], k == 0, k == 7};
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL stall_bit%0d got=%b exp=%b", k, obs, e);
      end
      if (ser_ready) k++;
    end
    ser_ready = 1'b1;
    total++;
    if (k != 8 || stall != 3) begin
      bad++;
      $display("FAIL stall_count got=%0d/%0d exp=8/3", k, stall);
    end
    @(negedge clk);
    total++;
    if (obs !== 6'b001000) begin
      bad++;
      $display("FAIL stall_ready got=%b exp=001000", obs);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    par_in = 8'hFF;
    load_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      e = {3'b110, 1'b1, i == 0, 1'b0};
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL ff_bit%0d got=%b exp=%b", i, obs, e);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (obs !== 6'b001000) begin
      bad++;
      $display("FAIL midrst_state got=%b exp=001000", obs);
    end
    @(negedge clk);
    total++;
    if (obs !== 6'b001000) begin
      bad++;
      $display("FAIL midrst_noresume got=%b exp=001000", obs);
    end
    par_in = 8'h00;
    load_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      e = {3'b110, 1'b0, i == 0, i == 7};
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL zero_bit%0d got=%b exp=%b", i, obs, e);
      end
    end
    @(negedge clk);
    total++;
    if (obs !== 6'b001000) begin
      bad++;
      $display("FAIL zero_ready got=%b exp=001000", obs);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:7] sa;
    logic [0:7] sb;
    sa = 8'b10101010;
    sb = 8'b01010101;
    @(negedge clk);
    par_in = 8'hAA;
    load_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      par_in = 8'h55;
      e = {3'b110, sa[i], i == 0, i == 7};
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL aa_bit%0d got=%b exp=%b", i, obs, e);
      end
    end
    @(negedge clk);
    total++;
    if (obs !== 6'b001000) begin
      bad++;
      $display("FAIL b2b_gap got=%b exp=001000", obs);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      e = {3'b110, sb[i], i == 0, i == 7};
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL b55_bit%0d got=%b exp=%b", i, obs, e);
      end
    end
    @(negedge clk);
    total++;
    if (obs !== 6'b001000) begin
      bad++;
      $display("FAIL b2b_ready got=%b exp=001000", obs);
    end
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    logic [0:8] s1;
    logic [0:8] s2;
    s1 = 9'b101001010;
    s2 = 9'b000001111;
    @(negedge clk);
    par_in = 8'hA5;
    load_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      e = {3'b110, s1[i], i == 0, i == 8};
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL par_a5_bit%0d got=%b exp=%b", i, obs, e);
      end
    end
    @(negedge clk);
    par_in = 8'h07;
    load_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      e = {3'b110, s2[i], i == 0, i == 8};
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL par_07_bit%0d got=%b exp=%b", i, obs, e);
      end
    end
    @(negedge clk);
    total++;
    if (obs !== 6'b001000) begin
      bad++;
      $display("FAIL par_ready got=%b exp=001000", obs);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef PISO_PARITY_EN
    test_parity();
`else
    test_msb_a5();
    test_lsb_01();
    test_stall_c3();
    test_reset_mid();
    test_back_to_back();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
